// File: rtl/data_mem_unit.sv
// Byte-addressable data memory for the MIPS memory stage.
// Handles sb/sh/sw with byte enables and lb/lbu/lh/lhu/lw with extension.
// Load latency is READ_LAT cycles. Misaligned accesses are flagged on rsp_err.
module data_mem_unit #(
  parameter int DEPTH_WORDS = 64,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, WAIT} state_t;

  // everything a load needs to remember until its response cycle
  typedef struct packed {
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [1:0]    size;
    logic          uns;
    logic          err;
  } ld_t;

  state_t          state;
  logic [2:0]      cnt;
  ld_t             ld;
  logic [3:0][7:0] mem [DEPTH_WORDS];

  logic            acc;
  logic            is_byte;
  logic            is_half;
  logic            mis;
  logic [AW-1:0]   idx;
  logic [3:0]      be;
  logic [3:0][7:0] wlanes;
  ld_t             cur;

  // upper address bits deliberately ignored: addresses wrap modulo depth
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:AW+2]};

  // request decode: index, misalignment, byte enables, replicated store lanes
  always_comb begin
    acc     = req_valid & req_ready;
    idx     = req_addr[AW+1:2];
    is_byte = (req_size == 2'b00);
    is_half = (req_size == 2'b01);
    mis     = (is_half & req_addr[0]) |
              (!is_byte & !is_half & (req_addr[1:0] != 2'b00));
    if (is_byte) begin
      be     = 4'b0001 << req_addr[1:0];
      wlanes = {4{req_wdata[7:0]}};
    end else if (is_half) begin
      be     = req_addr[1] ? 4'b1100 : 4'b0011;
      wlanes = {2{req_wdata[15:0]}};
    end else begin
      be     = 4'b1111;
      wlanes = req_wdata;
    end
    cur.idx  = idx;
    cur.lane = req_addr[1:0];
    cur.size = req_size;
    cur.uns  = req_unsigned;
    cur.err  = mis;
  end

  // lane select plus sign/zero extension; misaligned loads return zero
  function automatic logic [31:0] extract(input logic [31:0] w, input ld_t r);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = w[{r.lane, 3'b000} +: 8];
    h = r.lane[1] ? w[31:16] : w[15:0];
    case (r.size)
      2'b00:   res = r.uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   res = r.uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: res = w;
    endcase
    if (r.err) res = 32'h0;
    return res;
  endfunction

  // byte-enable write for accepted aligned stores; array is never reset
  always_ff @(posedge clk) begin
    if (acc && req_we && !mis) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[idx][k] <= wlanes[k];
    end
  end

  // IDLE/WAIT controller with registered handshake and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      ld        <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (acc && req_we) begin
            rsp_err <= mis;
          end else if (acc) begin
            ld <= cur;
            if (READ_LAT == 1) begin
              // single-cycle load: answer straight away, stay ready
              rsp_valid <= 1'b1;
              rsp_rdata <= extract(mem[idx], cur);
              rsp_err   <= mis;
            end else begin
              state     <= WAIT;
              req_ready <= 1'b0;
              cnt       <= 3'(READ_LAT - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          // memory is sampled here, so the data reflects the array at response time
          if (cnt == 3'd1) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= extract(mem[ld.idx], ld);
            rsp_err   <= ld.err;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: two instances (READ_LAT=1 and READ_LAT=3) checked
// every cycle against a byte-array reference model, plus literal checks.
module tb_data_mem_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        rv[2], rdy[2], rwe[2], runs[2], vld[2], err[2];
  logic [1:0]  rsz[2];
  logic [31:0] radr[2], rwd[2], rdat[2];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  data_mem_unit #(.DEPTH_WORDS(64), .READ_LAT(1)) dut0 (
    .clk(clk), .reset(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(rwe[0]),
    .req_size(rsz[0]), .req_unsigned(runs[0]), .req_addr(radr[0]), .req_wdata(rwd[0]),
    .rsp_valid(vld[0]), .rsp_rdata(rdat[0]), .rsp_err(err[0]));

  data_mem_unit #(.DEPTH_WORDS(64), .READ_LAT(3)) dut1 (
    .clk(clk), .reset(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(rwe[1]),
    .req_size(rsz[1]), .req_unsigned(runs[1]), .req_addr(radr[1]), .req_wdata(rwd[1]),
    .rsp_valid(vld[1]), .rsp_rdata(rdat[1]), .rsp_err(err[1]));

  // ---------------- reference model ----------------
  logic [7:0]  mm [2][256];
  logic        m_ready[2], m_valid[2], m_err[2], m_pend[2], m_perr[2];
  logic [31:0] m_rdata[2], m_res[2];
  int          m_due[2];
  int          cyc = 0;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] mload(input int d, input logic [1:0] sz,
                                        input logic uns, input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = a[7:0];
    h = {mm[d][b + 8'd1], mm[d][b]};
    case (sz)
      2'd0:    return uns ? {24'h0, mm[d][b]} : {{24{mm[d][b][7]}}, mm[d][b]};
      2'd1:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return {mm[d][b + 8'd3], mm[d][b + 8'd2], mm[d][b + 8'd1], mm[d][b]};
    endcase
  endfunction

  task automatic mstore(input int d, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
    logic [7:0] b;
    b = a[7:0];
    mm[d][b] = wd[7:0];
    if (sz != 2'd0) mm[d][b + 8'd1] = wd[15:8];
    if (sz[1]) begin
      mm[d][b + 8'd2] = wd[23:16];
      mm[d][b + 8'd3] = wd[31:24];
    end
  endtask

  // model: a load accepted at edge n answers at edge n+L-1 with the data as of acceptance
  initial forever begin
    logic rn, ms;
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_ready[d] = 1'b1; m_valid[d] = 1'b0; m_err[d] = 1'b0;
        m_rdata[d] = 32'h0; m_pend[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        rn = m_ready[d];
        m_valid[d] = 1'b0;
        m_err[d] = 1'b0;
        if (rv[d] && rn) begin
          ms = misal(rsz[d], radr[d]);
          if (rwe[d]) begin
            if (!ms) mstore(d, rsz[d], radr[d], rwd[d]);
            m_err[d] = ms;
          end else begin
            m_res[d]   = ms ? 32'h0 : mload(d, rsz[d], runs[d], radr[d]);
            m_perr[d]  = ms;
            m_pend[d]  = 1'b1;
            m_due[d]   = cyc + lat(d) - 1;
            m_ready[d] = 1'b0;
          end
        end
        if (m_pend[d] && m_due[d] == cyc) begin
          m_pend[d]  = 1'b0;
          m_valid[d] = 1'b1;
          m_rdata[d] = m_res[d];
          m_err[d]   = m_perr[d];
          m_ready[d] = 1'b1;
        end
      end
      cyc++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("ready%0d", d), 32'(rdy[d]), 32'(m_ready[d]));
        check($sformatf("valid%0d", d), 32'(vld[d]), 32'(m_valid[d]));
        check($sformatf("err%0d", d),   32'(err[d]), 32'(m_err[d]));
        check($sformatf("rdata%0d", d), rdat[d], m_rdata[d]);
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic issue(input int d, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    while (!rdy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout dut%0d got=ready_low want=ready_high", d);
    end
    rv[d] = 1'b1; rwe[d] = we; rsz[d] = sz; runs[d] = uns; radr[d] = a; rwd[d] = wd;
    @(posedge clk);
    @(negedge clk);
    rv[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d, input string nm, input logic [31:0] ed, input logic ee);
    int n = 0;
    while (!vld[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_valid"}, 32'(vld[d]), 32'd1);
    check({nm, "_data"}, rdat[d], ed);
    check({nm, "_err"}, 32'(err[d]), 32'(ee));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rwe[d] = 1'b0; rsz[d] = 2'd0; runs[d] = 1'b0;
      radr[d] = 32'h0; rwd[d] = 32'h0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(rdy[1]), 32'd1);
    check("rst_valid", 32'(vld[1]), 32'd0);
    check("rst_rdata", rdat[1], 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // fill both memories so later random loads read defined data
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 64; w++) issue(d, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);

    // READ_LAT=1 directed
    issue(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hA1B2C3D4);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    wait_rsp(0, "lw10", 32'hA1B2C3D4, 1'b0);
    issue(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h00000080);
    issue(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    wait_rsp(0, "lb11", 32'hFFFFFF80, 1'b0);
    issue(0, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    wait_rsp(0, "lbu11", 32'h00000080, 1'b0);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    wait_rsp(0, "lw10b", 32'hA1B280D4, 1'b0);
    issue(0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h00008001);
    issue(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    wait_rsp(0, "lh12", 32'hFFFF8001, 1'b0);
    issue(0, 1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
    wait_rsp(0, "lh13_mis", 32'h0, 1'b1);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    wait_rsp(0, "lw10c", 32'h800180D4, 1'b0);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h5);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    wait_rsp(0, "wrap", 32'h5, 1'b0);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h2, 32'h9);
    check("sw_mis_err", 32'(err[0]), 32'd1);
    check("sw_mis_novalid", 32'(vld[0]), 32'd0);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    wait_rsp(0, "sw_mis_nowrite", 32'h5, 1'b0);

    // READ_LAT=3 timing
    issue(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678);
    issue(1, 1'b1, 2'd2, 1'b0, 32'h24, 32'hCAFEF00D);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    check("l3_t1_ready", 32'(rdy[1]), 32'd0);
    check("l3_t1_valid", 32'(vld[1]), 32'd0);
    @(negedge clk);
    check("l3_t2_ready", 32'(rdy[1]), 32'd0);
    check("l3_t2_valid", 32'(vld[1]), 32'd0);
    @(negedge clk);
    check("l3_t3_ready", 32'(rdy[1]), 32'd1);
    check("l3_t3_valid", 32'(vld[1]), 32'd1);
    check("l3_t3_data", rdat[1], 32'h12345678);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0);
    check("l3_b2b_accept", 32'(rdy[1]), 32'd0);
    wait_rsp(1, "l3_second", 32'hCAFEF00D, 1'b0);

    // reset in the middle of a load
    issue(1, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("rst_drop_valid", 32'(vld[1]), 32'd0);
      check("rst_drop_ready", 32'(rdy[1]), 32'd1);
    end
    issue(1, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0);
    wait_rsp(1, "rst_mem_kept1", 32'hCAFEF00D, 1'b0);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    wait_rsp(0, "rst_mem_kept0", 32'h800180D4, 1'b0);

    // randomized traffic, checked by the per-cycle compare
    for (int d = 0; d < 2; d++) begin
      repeat (300) begin
        issue(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 1023)), $urandom);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      repeat (6) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end
endmodule
